// File: rtl/bus_arbiter_16_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_16_if
// Handshake bundle between the 16 requesting units and the round-robin
// arbiter that steers the shared 32-bit bus multiplexer.
//
// Signals:
//   req          [15:0] request vector, bit i = requester i wants the bus
//   done                current owner has finished its transfer
//   gnt          [15:0] one-hot grant, all-zero when nobody owns the bus
//   sel          [3:0]  mux select, index of current/last owner
//   valid               a grant is active
//   timeout_err         one-cycle pulse on a forced release
//
// Modports:
//   master - requester side (drives req/done, observes the grant)
//   slave  - arbiter side (observes req/done, drives the grant)
// ---------------------------------------------------------------------------
interface bus_arbiter_16_if;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        valid;
  logic        timeout_err;

  modport master (
    output req,
    output done,
    input  gnt,
    input  sel,
    input  valid,
    input  timeout_err
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output sel,
    output valid,
    output timeout_err
  );
endinterface

// File: rtl/bus_arbiter_16.sv
// ---------------------------------------------------------------------------
// bus_arbiter_16
// Round-robin arbiter sharing one 32-bit datapath among 16 requesters.
// Exactly one requester is granted at a time; the grant is held until the
// owner raises done, drops its request, or (optionally) times out. After
// every release the priority pointer moves to the requester just after the
// previous owner, so every requester is served in turn.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  asynchronous, active-high reset
//   bus    bus_arbiter_16_if.slave (req, done in; gnt, sel, valid,
//          timeout_err out). All outputs come straight from registers.
//
// Configuration macro:
//   ARB_TIMEOUT_EN - when defined, a grant held for TIMEOUT cycles without
//                    done is forcibly released and timeout_err pulses for
//                    one cycle. TIMEOUT (2..255, default 16) exists only in
//                    this build. When undefined, no counter is built and
//                    timeout_err is tied low.
// ---------------------------------------------------------------------------
module bus_arbiter_16
`ifdef ARB_TIMEOUT_EN
  #(parameter int TIMEOUT = 16)
`endif
(
  input logic             clk,
  input logic             reset,
  bus_arbiter_16_if.slave bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  ptr;
  logic [3:0]  ptr_n;
  logic [3:0]  owner;
  logic [3:0]  owner_n;
  logic [15:0] gnt;
  logic [15:0] gnt_n;
  logic        valid;
  logic        valid_n;
  logic        release_now;
  logic [3:0]  pick;
  logic        found;

`ifdef ARB_TIMEOUT_EN
  // The counter starts at 0 on the grant edge, so reaching TIMEOUT-1
  // means the owner has held the bus for TIMEOUT cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;
  logic [7:0] cnt_n;
  logic       timed_out;
  logic       terr;
  logic       terr_n;
`endif

  // Round-robin pick: scan ptr, ptr+1, ... and let the 4-bit sum wrap
  // naturally from 15 back to 0. The first requester found wins.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found && bus.req[ptr + 4'(i)]) begin
        pick  = ptr + 4'(i);
        found = 1'b1;
      end
    end
  end

  // Next-state and next-output logic. Every output has a register, so the
  // values computed here only become visible after the next rising edge.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    owner_n     = owner;
    gnt_n       = gnt;
    valid_n     = valid;
    release_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_n       = cnt;
    terr_n      = 1'b0;
    timed_out   = (cnt == CNT_LAST);
`endif

    case (state)
      IDLE: begin
        if (bus.req != '0) begin
          owner_n = pick;
          gnt_n   = 16'b1 << pick;
          valid_n = 1'b1;
          state_n = GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_n   = 8'd0;
`endif
        end
      end

      GRANT: begin
        release_now = bus.done || !bus.req[owner];
`ifdef ARB_TIMEOUT_EN
        // done wins over the timeout; only a genuinely hung owner is
        // flagged as an error.
        release_now = release_now || timed_out;
        terr_n      = timed_out && !bus.done;
        cnt_n       = cnt + 8'd1;
`endif
        if (release_now) begin
          // owner is left untouched so sel keeps the mux output stable.
          gnt_n   = '0;
          valid_n = 1'b0;
          ptr_n   = owner + 4'd1;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register; reset drops any grant in progress immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 4'd0;
      owner <= 4'd0;
      gnt   <= '0;
      valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt   <= 8'd0;
      terr  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      gnt   <= gnt_n;
      valid <= valid_n;
`ifdef ARB_TIMEOUT_EN
      cnt   <= cnt_n;
      terr  <= terr_n;
`endif
    end
  end

  assign bus.gnt   = gnt;
  assign bus.sel   = owner;
  assign bus.valid = valid;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_err = terr;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule
